// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux, with a valid/ready output register.
// Optional ARB_LOCK_EN adds lock[3:0] so a winner can hold the path across captures.
module mux4_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
`ifdef ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic [1:0]       r_last;
  logic [WIDTH-1:0] r_y;

  logic [3:0]       w_lock_mask;
  logic [3:0]       w_elig;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_found;
  logic             w_capture;
  logic [WIDTH-1:0] w_mux;

`ifdef ARB_LOCK_EN
  logic             r_locked;
  logic [1:0]       r_lock_idx;
  assign w_lock_mask = r_locked ? (4'b0001 << r_lock_idx) : 4'b1111;
`else
  assign w_lock_mask = 4'b1111;
`endif

  // Masking the requester granted last cycle keeps its stale word from being re-captured.
  assign w_elig = req & ~r_gnt & w_lock_mask;

  always_comb begin
    w_win   = r_last;
    w_found = 1'b0;
    w_idx   = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_capture = w_found & ((r_state == EMPTY) | y_ready);

  always_comb begin
    w_mux = a0;
    case (w_win)
      2'd0: w_mux = a0;
      2'd1: w_mux = a1;
      2'd2: w_mux = a2;
      2'd3: w_mux = a3;
      default: w_mux = a0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_capture)              w_state_nxt = FULL;
      FULL:  if (y_ready && !w_capture)  w_state_nxt = EMPTY;
      default:                           w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_y    <= '0;
      r_sel  <= 2'd0;
      r_last <= 2'd3;
      r_gnt  <= 4'b0000;
`ifdef ARB_LOCK_EN
      r_locked   <= 1'b0;
      r_lock_idx <= 2'd0;
`endif
    end else begin
      r_gnt <= 4'b0000;
      if (w_capture) begin
        r_y   <= w_mux;
        r_sel <= w_win;
        r_gnt <= 4'b0001 << w_win;
`ifdef ARB_LOCK_EN
        // Pointer freezes while locked; rotation resumes from the releasing winner.
        if (lock[w_win]) begin
          r_locked   <= 1'b1;
          r_lock_idx <= w_win;
        end else begin
          r_locked <= 1'b0;
          r_last   <= w_win;
        end
`else
        r_last <= w_win;
`endif
      end
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign y       = r_y;
  assign y_valid = (r_state == FULL);
  assign busy    = y_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter: reset, single request,
// fairness, backpressure, stale-data guard, idle ready, reset mid-transfer.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        clrn;
  logic [3:0]  req;
  logic [31:0] a [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        busy;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  int nchk = 0;
  int nerr = 0;

  mux4_rr_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .req(req),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
  );

  // {y_valid, busy, gnt, sel, y}
  wire [39:0] w_obs = {y_valid, busy, gnt, sel, y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clrn = 1'b0; req = 4'b0000; y_ready = 1'b0;
    tick(); tick();
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    logic [39:0] e;
    clrn = 1'b0; req = 4'b1111; y_ready = 1'b0;
    tick(); tick();
    e = 40'h0;
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL reset_state: got %h want %h", w_obs, e); end
    clrn = 1'b1;
    tick();
    e = {2'b11, 4'b0001, 2'd0, a[0]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL reset_first_win: got %h want %h", w_obs, e); end
    req = 4'b0000; y_ready = 1'b1;
    tick();
    e = {2'b00, 4'b0000, 2'd0, a[0]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL reset_drain: got %h want %h", w_obs, e); end
  endtask

  task automatic test_single();
    logic [39:0] e;
    a[2] = 32'hDEADBEEF; req = 4'b0100; y_ready = 1'b0;
    tick();
    e = {2'b11, 4'b0100, 2'd2, 32'hDEADBEEF};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL single_capture: got %h want %h", w_obs, e); end
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = {2'b11, 4'b0000, 2'd2, 32'hDEADBEEF};
      nchk++; if (w_obs !== e) begin nerr++; $display("FAIL single_hold%0d: got %h want %h", i, w_obs, e); end
    end
    y_ready = 1'b1;
    tick();
    e = {2'b00, 4'b0000, 2'd2, 32'hDEADBEEF};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL single_drain: got %h want %h", w_obs, e); end
  endtask

  task automatic test_fairness();
    logic [39:0] e;
    int w;
    apply_reset();
    req = 4'b1111; y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      w = i % 4;
      e = {2'b11, 4'(1 << w), 2'(w), a[w]};
      nchk++; if (w_obs !== e) begin nerr++; $display("FAIL fair_cap%0d: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] e;
    req = 4'b0011; y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = {2'b11, 4'b0000, 2'd0, a[0]};
      nchk++; if (w_obs !== e) begin nerr++; $display("FAIL bp_stall%0d: got %h want %h", i, w_obs, e); end
    end
    y_ready = 1'b1;
    tick();
    e = {2'b11, 4'b0010, 2'd1, a[1]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL bp_release: got %h want %h", w_obs, e); end
    req = 4'b0000;
    tick();
    e = {2'b00, 4'b0000, 2'd1, a[1]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL bp_drain: got %h want %h", w_obs, e); end
  endtask

  task automatic test_stale_guard();
    logic [39:0] e;
    apply_reset();
    req = 4'b0010; y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) e = {2'b11, 4'b0010, 2'd1, a[1]};
      else            e = {2'b00, 4'b0000, 2'd1, a[1]};
      nchk++; if (w_obs !== e) begin nerr++; $display("FAIL stale_cyc%0d: got %h want %h", i, w_obs, e); end
    end
    req = 4'b0000;
  endtask

  task automatic test_idle_ready();
    logic [39:0] e;
    y_ready = 1'b1; req = 4'b0000;
    tick(); tick();
    e = {2'b00, 4'b0000, 2'd1, a[1]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL idle_ready: got %h want %h", w_obs, e); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] e;
    req = 4'b0100; y_ready = 1'b0;
    tick();
    e = {2'b11, 4'b0100, 2'd2, a[2]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL mid_capture: got %h want %h", w_obs, e); end
    clrn = 1'b0; req = 4'b0000;
    tick();
    e = 40'h0;
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL mid_reset: got %h want %h", w_obs, e); end
    clrn = 1'b1;
    tick();
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL mid_no_gnt: got %h want %h", w_obs, e); end
    req = 4'b1111;
    tick();
    e = {2'b11, 4'b0001, 2'd0, a[0]};
    nchk++; if (w_obs !== e) begin nerr++; $display("FAIL mid_ptr_reset: got %h want %h", w_obs, e); end
    req = 4'b0000;
  endtask

  initial begin
    clrn = 1'b0; req = 4'b0000; y_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    a[0] = 32'h1111_0000; a[1] = 32'h2222_0001;
    a[2] = 32'h3333_0002; a[3] = 32'h4444_0003;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_stale_guard();
    test_idle_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and output register that shares one 4:1 32-bit selection path among four requesters.
- Picks one requester, drives the 2-bit select (sel) used by the four-input word mux, and captures the chosen word into a register.
- Presents the captured word downstream on a valid/ready handshake.
- Sits between the requester ports (e.g. result sources competing for one writeback/bus path) and the single shared consumer.

Parameters:
- WIDTH, 32, data word width of a0..a3 and y.

Ports:
- clk  input  1  rising-edge clock.
- clrn  input  1  synchronous active-low reset.
- req  input  4  per-requester request; bit i qualifies ai.
- a0  input  WIDTH  requester 0 data.
- a1  input  WIDTH  requester 1 data.
- a2  input  WIDTH  requester 2 data.
- a3  input  WIDTH  requester 3 data.
- gnt  output  4  registered one-hot pulse: bit i high for exactly one cycle after ai was captured.
- sel  output  2  index of the most recent winner; drives the word mux select.
- y  output  WIDTH  captured word.
- y_valid  output  1  y holds an unconsumed word.
- y_ready  input  1  downstream accepts y when y_valid & y_ready.
- busy  output  1  equals y_valid.

Behaviour:
- Reset: sampled on clk rising edge when clrn=0.
  - y=0, y_valid=0, gnt=0, sel=0.
  - Internal last-winner pointer=3, so requester 0 has first priority.
  - Reset mid-transfer discards the held word; no gnt is issued for it.
- Two states:
  - EMPTY (y_valid=0).
  - FULL (y_valid=1).
- Eligible set: elig = req & ~gnt. A requester whose gnt is high this cycle is excluded, which prevents re-capturing stale data.
- Capture condition: |elig & (EMPTY | y_ready).
- Winner selection: first set bit of elig scanning (last+1), (last+2), (last+3), last, all mod 4.
- On capture at edge n:
  - y <= a[winner] (mux of a0..a3 by winner index).
  - sel <= winner, last <= winner, y_valid <= 1.
  - gnt <= one-hot(winner) for cycle n+1 only.
- Latency: req seen in EMPTY at cycle n gives y_valid=1 and gnt in cycle n+1.
- FULL with y_ready=1 and no capture: y_valid <= 0; y, sel and last hold.
- FULL with y_ready=1 and capture: back-to-back transfer; y_valid stays 1 and the new word replaces y. Throughput is 1 word/cycle.
- FULL with y_ready=0: y, sel, y_valid hold; gnt <= 0; no arbitration happens.
- gnt is 0 in every cycle not immediately following a capture.
- Requester protocol: hold req and ai stable until gnt is seen; after that, drop req or present the next word.
- Simultaneous requests: exactly one winner per capture; the pointer guarantees each of 4 persistent requesters wins once every 4 captures.
- y_ready with y_valid=0 is ignored.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input lock[3:0].
  - If lock[winner]=1 at capture, the arbiter enters locked mode: elig is further masked to the locked requester only, and last does not advance.
  - Locked mode ends with the first capture for which lock[winner]=0; normal round-robin resumes from that winner.
  - Reset clears locked mode.
  - gnt masking still applies, so in locked mode the locked requester captures at most every other cycle.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset: clrn=0 for 2 cycles with req=4'b1111 -> y=0, y_valid=0, gnt=0, sel=0; after release, first capture is requester 0 and gnt=4'b0001.
- Single request: req=4'b0100, a2=32'hDEADBEEF, y_ready=0 -> next cycle y=32'hDEADBEEF, y_valid=1, sel=2'd2, gnt=4'b0100 for exactly 1 cycle; y holds while y_ready=0.
- Fairness: req=4'b1111 held, y_ready=1 -> winners rotate 0,1,2,3,0; gnt seen one-hot 0001,0010,0100,1000,0001; y_valid stays 1.
- Backpressure: FULL, y_ready=0 for 5 cycles with req=4'b0011 -> no new capture and gnt=0 during those cycles; y_ready=1 gives a back-to-back capture of the next requester in round-robin order.
- Stale-data guard: only req[1]=1, held high through its gnt cycle, y_ready=1 -> captures occur at most every other cycle; no duplicate capture in the gnt cycle.
- With ARB_LOCK_EN: lock=4'b0010, req=4'b1111 -> requester 1 wins consecutive captures; lock=0 -> next winner is requester 2.
